// File: rtl/cork_stock_counter_pkg.sv
// Shared definitions for the cork stock counter: refill FSM states and
// decrement-mode encodings.
package cork_stock_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } refill_state_e;

    localparam int DECR_LEVEL = 0;
    localparam int DECR_EDGE  = 1;

endpackage

// File: rtl/cork_stock_counter_rise_pulse.sv
// Rising-edge detector. prev resets to 1 so an input already high when reset
// is released does not count as an edge.
module rise_pulse (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= 1'b1;
        end else begin
            prev <= sig;
        end
    end

    assign pulse = sig & ~prev;

endmodule

// File: rtl/cork_stock_counter.sv
// Saturating cork stock counter with edge-counted increment, level/edge
// decrement, threshold alarms, sticky error and automatic refill handshake.
module cork_stock_counter
    import cork_stock_counter_pkg::*;
#(
    parameter int WIDTH         = 5,
    parameter int MAX_VALUE     = 31,
    parameter int INIT_VALUE    = 31,
    parameter int LOW_THRESH    = 14,
    parameter int ALARM_VALUE   = 14,
    parameter int REFILL_AMOUNT = 10,
    parameter int DECR_MODE     = DECR_LEVEL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             incr_en,
    input  logic             decr_en,
    input  logic             auto_refill_en,
    input  logic             refill_ack,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic             low_flag,
    output logic             match_flag,
    output logic             empty,
    output logic             full,
    output logic             refill_req,
    output logic             err_flag
);

    // Two guard bits: one for the sign, one for headroom above MAX_VALUE.
    localparam int SUM_W = WIDTH + 2;
    localparam logic signed [SUM_W-1:0] ZERO_S   = '0;
    localparam logic signed [SUM_W-1:0] ONE_S    = SUM_W'(1);
    localparam logic signed [SUM_W-1:0] MAX_S    = SUM_W'(MAX_VALUE);
    localparam logic signed [SUM_W-1:0] REFILL_S = SUM_W'(REFILL_AMOUNT);

    function automatic logic [WIDTH-1:0] sat_clamp(input logic signed [SUM_W-1:0] s);
        if (s[SUM_W-1]) begin
            return '0;
        end
        if (s > MAX_S) begin
            return WIDTH'(MAX_VALUE);
        end
        return s[WIDTH-1:0];
    endfunction

    function automatic logic out_of_range(input logic signed [SUM_W-1:0] s);
        return s[SUM_W-1] || (s > MAX_S);
    endfunction

    refill_state_e           state, state_next;
    logic [WIDTH-1:0]        count;
    logic                    err_r;
    logic                    incr_p;
    logic                    decr_p;
    logic                    refill_apply;
    logic signed [SUM_W-1:0] delta;
    logic signed [SUM_W-1:0] sum;

    rise_pulse u_incr_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (incr_en),
        .pulse (incr_p)
    );

    generate
        if (DECR_MODE == DECR_EDGE) begin : g_decr_edge
            rise_pulse u_decr_edge (
                .clk   (clk),
                .reset (reset),
                .sig   (decr_en),
                .pulse (decr_p)
            );
        end else begin : g_decr_level
            assign decr_p = decr_en;
        end
    endgenerate

    // An ack only counts while a request is actually outstanding.
    assign refill_apply = (state == ST_REQ) && refill_ack;

    always_comb begin
        delta = (incr_p ? ONE_S : ZERO_S) - (decr_p ? ONE_S : ZERO_S)
              + (refill_apply ? REFILL_S : ZERO_S);
        sum   = $signed({2'b00, count}) + delta;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= WIDTH'(INIT_VALUE);
            err_r <= 1'b0;
        end else begin
            count <= sat_clamp(sum);
            if (out_of_range(sum)) begin
                err_r <= 1'b1;
            end else if (clr_err) begin
                err_r <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // HOLD gives q one cycle to settle before low_flag is looked at again.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (auto_refill_en && low_flag) state_next = ST_REQ;
            ST_REQ:  if (refill_ack) state_next = ST_HOLD;
            ST_HOLD: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign q          = count;
    assign err_flag   = err_r;
    assign refill_req = (state == ST_REQ);
    assign low_flag   = (count <= WIDTH'(LOW_THRESH));
    assign match_flag = (count == WIDTH'(ALARM_VALUE));
    assign empty      = (count == '0);
    assign full       = (count == WIDTH'(MAX_VALUE));

endmodule

// File: tb/tb_cork_stock_counter.sv
// Scoreboard bench: level-mode and edge-mode counters driven in parallel,
// checked against a behavioural stock model.
module tb_cork_stock_counter;

    localparam int W    = 5;
    localparam int MAXV = 31;
    localparam int INIT = 31;
    localparam int LOWT = 14;
    localparam int ALRM = 14;
    localparam int RA   = 10;
    localparam int IDLE = 0;
    localparam int REQ  = 1;
    localparam int HOLD = 2;

    typedef struct packed {
        logic [W-1:0] q;
        logic low, match, empty, full, req, err;
    } exp_t;

    typedef struct {
        int cnt;
        int st;
        bit err;
        bit pi;
        bit pd;
    } mdl_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic incr_en = 1'b0, decr_en = 1'b0, auto_refill_en = 1'b0, refill_ack = 1'b0, clr_err = 1'b0;
    logic [W-1:0] q0, q1;
    logic low0, low1, match0, match1, empty0, empty1, full0, full1, req0, req1, err0, err1;

    int checks = 0;
    int failures = 0;
    mdl_t m[2];
    exp_t sb[$];

    always #5 clk = ~clk;

    cork_stock_counter #(.WIDTH(W), .MAX_VALUE(MAXV), .INIT_VALUE(INIT), .LOW_THRESH(LOWT),
                         .ALARM_VALUE(ALRM), .REFILL_AMOUNT(RA), .DECR_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .incr_en(incr_en), .decr_en(decr_en),
        .auto_refill_en(auto_refill_en), .refill_ack(refill_ack), .clr_err(clr_err),
        .q(q0), .low_flag(low0), .match_flag(match0), .empty(empty0), .full(full0),
        .refill_req(req0), .err_flag(err0));

    cork_stock_counter #(.WIDTH(W), .MAX_VALUE(MAXV), .INIT_VALUE(INIT), .LOW_THRESH(LOWT),
                         .ALARM_VALUE(ALRM), .REFILL_AMOUNT(RA), .DECR_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .incr_en(incr_en), .decr_en(decr_en),
        .auto_refill_en(auto_refill_en), .refill_ack(refill_ack), .clr_err(clr_err),
        .q(q1), .low_flag(low1), .match_flag(match1), .empty(empty1), .full(full1),
        .refill_req(req1), .err_flag(err1));

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic exp_t act_out(input int i);
        exp_t a;
        if (i == 0) a = '{q0, low0, match0, empty0, full0, req0, err0};
        else        a = '{q1, low1, match1, empty1, full1, req1, err1};
        return a;
    endfunction

    function automatic exp_t model_out(input int i);
        exp_t e;
        e.q     = W'(m[i].cnt);
        e.low   = m[i].cnt <= LOWT;
        e.match = m[i].cnt == ALRM;
        e.empty = m[i].cnt == 0;
        e.full  = m[i].cnt == MAXV;
        e.req   = m[i].st == REQ;
        e.err   = m[i].err;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) m[i] = '{INIT, IDLE, 1'b0, 1'b1, 1'b1};
    endtask

    // Instance i uses DECR_MODE = i.
    task automatic model_step(input int i, input bit inc, input bit dec, input bit au,
                              input bit ack, input bit clr);
        int ip, dp, add, sum;
        bit low;
        ip  = (inc && !m[i].pi) ? 1 : 0;
        dp  = (i == 1) ? ((dec && !m[i].pd) ? 1 : 0) : (dec ? 1 : 0);
        add = (m[i].st == REQ && ack) ? RA : 0;
        low = m[i].cnt <= LOWT;
        sum = m[i].cnt + ip - dp + add;
        if (sum < 0 || sum > MAXV) m[i].err = 1'b1;
        else if (clr)              m[i].err = 1'b0;
        m[i].cnt = (sum < 0) ? 0 : ((sum > MAXV) ? MAXV : sum);
        case (m[i].st)
            IDLE:    if (au && low) m[i].st = REQ;
            REQ:     if (ack) m[i].st = HOLD;
            default: m[i].st = IDLE;
        endcase
        m[i].pi = inc;
        m[i].pd = dec;
    endtask

    task automatic step(input bit inc, input bit dec, input bit au, input bit ack, input bit clr);
        incr_en = inc; decr_en = dec; auto_refill_en = au; refill_ack = ack; clr_err = clr;
        for (int i = 0; i < 2; i++) begin
            model_step(i, inc, dec, au, ack, clr);
            sb.push_back(model_out(i));
        end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input bit inc);
        incr_en = inc; decr_en = 1'b0; auto_refill_en = 1'b0; refill_ack = 1'b0; clr_err = 1'b0;
        reset = 1'b1;
        #1;
        chk("reset_req0_async", int'(req0), 0);
        chk("reset_req1_async", int'(req1), 0);
        model_reset();
        for (int i = 0; i < 2; i++) sb.push_back(model_out(i));
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: every falling edge the DUTs present one result each.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (sb.size() > 0) begin
                exp_t e, a;
                e = sb.pop_front();
                a = act_out(i);
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL sb_dut%0d t=%0t actual q=%0d l=%b m=%b e=%b f=%b r=%b err=%b required q=%0d l=%b m=%b e=%b f=%b r=%b err=%b",
                             i, $time, a.q, a.low, a.match, a.empty, a.full, a.req, a.err,
                             e.q, e.low, e.match, e.empty, e.full, e.req, e.err);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        #1;
        // Incr held high through reset release must not count.
        do_reset(1'b1);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("init_q", int'(q0), 31);
        chk("init_err", int'(err0), 0);

        // Level decrement down to the alarm value, then underflow.
        repeat (17) step(0, 1, 0, 0, 0);
        chk("lvl_q14", int'(q0), 14);
        chk("lvl_low", int'(low0), 1);
        chk("lvl_match", int'(match0), 1);
        chk("edge_decr_once", int'(q1), 30);
        repeat (14) step(0, 1, 0, 0, 0);
        chk("lvl_q0", int'(q0), 0);
        chk("lvl_err_before", int'(err0), 0);
        step(0, 1, 0, 0, 0);
        chk("under_q", int'(q0), 0);
        chk("under_empty", int'(empty0), 1);
        chk("under_err", int'(err0), 1);
        step(0, 0, 0, 0, 1);
        chk("clr_err", int'(err0), 0);

        // Climb to 20, then cancelling incr/decr.
        repeat (20) begin step(1, 0, 0, 0, 0); step(0, 0, 0, 0, 0); end
        chk("climb_q20", int'(q0), 20);
        step(1, 1, 0, 0, 0);
        chk("cancel_q", int'(q0), 20);
        chk("cancel_err", int'(err0), 0);
        step(0, 0, 0, 0, 0);
        repeat (11) begin step(1, 0, 0, 0, 0); step(0, 0, 0, 0, 0); end
        chk("full_q", int'(full0), 1);
        step(1, 0, 0, 0, 0);
        chk("over_q", int'(q0), 31);
        chk("over_err", int'(err0), 1);
        step(0, 0, 0, 0, 1);

        // Refill handshake from 14.
        repeat (17) step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("refill_req_rise", int'(req0), 1);
        repeat (4) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        chk("refill_q24", int'(q0), 24);
        chk("refill_req_fall", int'(req0), 0);
        repeat (3) step(0, 0, 1, 0, 0);
        chk("refill_no_rereq", int'(req0), 0);

        // Request stays pending while auto drops; ack at 28 clamps.
        repeat (10) step(0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        repeat (14) begin step(1, 0, 0, 0, 0); step(0, 0, 0, 0, 0); end
        chk("req_held_q28", int'(q0), 28);
        chk("req_held", int'(req0), 1);
        step(0, 0, 0, 1, 0);
        chk("refill_clamp_q", int'(q0), 31);
        chk("refill_clamp_err", int'(err0), 1);

        // Reset while requesting; ack right after release is ignored.
        step(0, 0, 0, 0, 1);
        repeat (17) step(0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("pre_reset_req", int'(req0), 1);
        do_reset(1'b0);
        step(0, 0, 1, 1, 0);
        chk("post_reset_q", int'(q0), 31);
        chk("post_reset_req", int'(req0), 0);

        // Randomised traffic against the model.
        repeat (600) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
        end

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
